// File: rtl/spart_rx.sv
// SPART receive engine: 2-flop rxd synchroniser, 16x oversampling 8N1 deserialiser and show-ahead receive FIFO.
// Define SPART_RX_PARITY_EN to receive 8E1 frames and report parity errors on parity_err.
module spart_rx #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rxd,
    input  logic                     brg_tick,
    input  logic                     rd,
    input  logic                     clr_err,
    output logic [7:0]               rx_data,
    output logic                     rda,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     framing_err,
    output logic                     overrun,
    output logic                     parity_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef SPART_RX_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    logic          sync1_q, rxs_q;
    state_t        state_q, state_d;
    logic [3:0]    sc_q, sc_d;
    logic [2:0]    bc_q, bc_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rda_q, rda_d;
    logic          framing_err_q, framing_err_d;
    logic          overrun_q, overrun_d;
    logic          push_s, fe_set_s, pe_set_s;
    logic          do_push_s, do_pop_s, ov_set_s;

    // Frame decoder: every transition is qualified by the 16x baud tick.
    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        bc_d     = bc_q;
        shift_d  = shift_q;
        push_s   = 1'b0;
        fe_set_s = 1'b0;
        pe_set_s = 1'b0;
        if (brg_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_d = S_START;
                        sc_d    = 4'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (sc_q == 4'd7) begin
                        sc_d = 4'd0;
                        bc_d = 3'd0;
                        if (!rxs_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
                S_DATA: begin
                    if (sc_q == 4'd15) begin
                        shift_d = {rxs_q, shift_q[7:1]};
                        sc_d    = 4'd0;
                        if (bc_q == 3'd7) begin
`ifdef SPART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bc_d = bc_q + 3'd1;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
`ifdef SPART_RX_PARITY_EN
                S_PARITY: begin
                    if (sc_q == 4'd15) begin
                        pe_set_s = ^{shift_q, rxs_q};
                        sc_d     = 4'd0;
                        state_d  = S_STOP;
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (sc_q == 4'd15) begin
                        sc_d = 4'd0;
                        if (rxs_q) begin
                            push_s  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            fe_set_s = 1'b1;
                            state_d  = S_WAIT_HI;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
                S_WAIT_HI: begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_HI;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FIFO bookkeeping; a pop frees room for a same-cycle push when full.
    always_comb begin
        do_pop_s  = rd && (count_q != {CW{1'b0}});
        do_push_s = push_s && ((count_q != FULL) || do_pop_s);
        ov_set_s  = push_s && !do_push_s;
        mem_d     = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = shift_q;
        end else begin
            mem_d = mem_q;
        end
        wr_ptr_d = do_push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        rx_data_d     = (count_d == {CW{1'b0}}) ? 8'h00 : mem_d[rd_ptr_d];
        rda_d         = (count_d != {CW{1'b0}});
        framing_err_d = fe_set_s ? 1'b1 : (clr_err ? 1'b0 : framing_err_q);
        overrun_d     = ov_set_s ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    end

    // State, FIFO and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b1;
            rxs_q         <= 1'b1;
            state_q       <= S_IDLE;
            sc_q          <= 4'd0;
            bc_q          <= 3'd0;
            shift_q       <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q      <= {PW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            count_q       <= {CW{1'b0}};
            rx_data_q     <= 8'h00;
            rda_q         <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync1_q       <= rxd;
            rxs_q         <= sync1_q;
            state_q       <= state_d;
            sc_q          <= sc_d;
            bc_q          <= bc_d;
            shift_q       <= shift_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rx_data_q     <= rx_data_d;
            rda_q         <= rda_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef SPART_RX_PARITY_EN
    logic parity_err_q, parity_err_d;

    // Sticky parity flag; a new mismatch wins over clr_err.
    always_comb begin
        parity_err_d = pe_set_s ? 1'b1 : (clr_err ? 1'b0 : parity_err_q);
    end

    // Parity flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data     = rx_data_q;
    assign rda         = rda_q;
    assign count       = count_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
Receive engine of the SPART. It synchronises the serial rxd line, oversamples it at 16x baud using the enable tick from the baud generator, and deserialises 8N1 frames, LSB first. Received bytes go into a small show-ahead FIFO. The SPART bus interface drains that FIFO on a data-register read (ioaddr 2'b00, iorw=1) and drives rda from its non-empty flag.

Parameters:
DEPTH, 4, receive FIFO depth in bytes; must be a power of 2 and at least 2.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous, active-high reset.
rxd  input  1  asynchronous serial input; idles high.
brg_tick  input  1  one-clk pulse at 16x baud from the baud generator.
rd  input  1  pop the FIFO head; asserted by the bus interface on a data read.
clr_err  input  1  clears the sticky error flags.
rx_data  output  8  FIFO head byte (show-ahead); 8'h00 when empty.
rda  output  1  receive data available (FIFO not empty).
count  output  $clog2(DEPTH)+1  current FIFO occupancy.
framing_err  output  1  sticky; set when a stop bit is sampled as 0.
overrun  output  1  sticky; set when a byte arrives while the FIFO is full.
parity_err  output  1  sticky; parity mismatch (see Optional Feature).

Behaviour:
- Reset values: rx_data=0, rda=0, count=0, all error flags=0, state=IDLE, FIFO empty, both synchroniser flops=1.
- Reset is synchronous and overrides everything. Reset mid-frame abandons the frame and empties the FIFO.
- rxd passes through a 2-flop synchroniser (rxs). All sampling uses rxs.
- The 4-bit sample counter (sc) and 3-bit bit counter (bc) advance only on cycles with brg_tick=1. When brg_tick=0 the FSM is frozen.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_HI.
- IDLE: on a tick with rxs=0, go to START with sc=0.
- START: at sc==7, rxs=0 goes to DATA (sc=0, bc=0); rxs=1 is a glitch and goes back to IDLE with nothing recorded.
- DATA: at sc==15, shift rxs into the MSB of the shift register (LSB-first frame) and reset sc. After the 8th bit (bc==7) go to PARITY if it is compiled in, otherwise STOP.
- STOP: at sc==15:
  - rxs=1: push the byte and go to IDLE.
  - rxs=0: set framing_err, discard the byte, go to WAIT_HI.
- WAIT_HI: stay until a tick with rxs=1, then go to IDLE. This handles a break (line held low) without spurious frames.
- Latency: rda=1 on the clk edge after the stop-bit sample tick.
- FIFO write: a push while full drops the byte, sets overrun, and leaves the contents unchanged.
- FIFO read: rd while empty is ignored. Pointers wrap modulo DEPTH.
- Push and rd on the same cycle:
  - When full: the pop occurs and the push is accepted; count stays DEPTH and overrun is not set.
  - When empty: the push is accepted and the rd is ignored; count becomes 1.
- rx_data always shows mem[rd_ptr] and updates on the edge after a pop.
- Error flags hold until clr_err or rst. If clr_err and a new error event occur on the same cycle, the flag is set (set wins).

Optional Feature:
Macro SPART_RX_PARITY_EN.
- Defined: frames are 8E1. The PARITY state samples at sc==15. If the XOR of the 8 data bits and the parity bit is not 0, parity_err is set; the byte is still pushed if the stop bit is valid.
- Undefined: no PARITY state, frames are 8N1, and parity_err is tied to 0.

Test Plan:
- brg_tick tied 1 (bit period 16 clk); drive 0x45 as start 0, bits 1,0,1,0,0,0,1,0, stop 1 -> rda=1 the clk after the stop-sample tick; rx_data=8'h45; count=1; no error flags; pulse rd -> rda=0, count=0.
- rxd low for 4 clk, then high -> no rda; FSM back in IDLE; a following 0xA5 frame is received correctly.
- Frame 0x3C with stop bit 0, then rxd held low 64 clk, then high -> framing_err=1; count=0; no phantom byte while low; a next frame 0x11 received OK; clr_err -> framing_err=0.
- DEPTH=4; send 0x01..0x05 with no reads -> count=4, overrun=1, rx_data=0x01; reads return 0x01..0x04 in order, then rda=0.
- FIFO full; assert rd on the same cycle as the 5th byte's push -> count=4, overrun=0, rx_data=0x02.
- Assert rst for 1 clk mid-DATA of a frame -> all outputs 0 next cycle; the remainder of the frame produces no byte; next full frame 0x7E received. With SPART_RX_PARITY_EN defined, 0x7E with parity bit 1 -> parity_err=1 and byte still stored.
